// File: rtl/axi4_pkg.sv
// Shared AXI4 master definitions: response codes and the
// command master state encoding.
package axi4_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_AW,
        ST_WR,
        ST_B,
        ST_AR,
        ST_RD,
        ST_DONE
    } mst_state_e;

endpackage

// File: rtl/axi4_if.sv
// Minimal AXI4 channel bundle (INCR bursts, single ID)
// with master and slave views.
interface axi4_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 16
);
    logic [ADDR_WIDTH-1:0] awaddr;
    logic [7:0]            awlen;
    logic [2:0]            awsize;
    logic                  awvalid;
    logic                  awready;

    logic [DATA_WIDTH-1:0] wdata;
    logic                  wlast;
    logic                  wvalid;
    logic                  wready;

    logic [1:0]            bresp;
    logic                  bvalid;
    logic                  bready;

    logic [ADDR_WIDTH-1:0] araddr;
    logic [7:0]            arlen;
    logic [2:0]            arsize;
    logic                  arvalid;
    logic                  arready;

    logic [DATA_WIDTH-1:0] rdata;
    logic [1:0]            rresp;
    logic                  rlast;
    logic                  rvalid;
    logic                  rready;

    modport master_mp (
        output awaddr, awlen, awsize, awvalid,
        input  awready,
        output wdata, wlast, wvalid,
        input  wready,
        input  bresp, bvalid,
        output bready,
        output araddr, arlen, arsize, arvalid,
        input  arready,
        input  rdata, rresp, rlast, rvalid,
        output rready
    );

    modport slave_mp (
        input  awaddr, awlen, awsize, awvalid,
        output awready,
        input  wdata, wlast, wvalid,
        output wready,
        output bresp, bvalid,
        input  bready,
        input  araddr, arlen, arsize, arvalid,
        output arready,
        output rdata, rresp, rlast, rvalid,
        input  rready
    );

endinterface

// File: rtl/axi4_cmd_master.sv
// Single-outstanding AXI4 burst master: turns one command into an
// AW/W/B or AR/R sequence and reports completion with a done pulse.
module axi4_cmd_master
    import axi4_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 16
) (
    input  logic                  ACLK,
    input  logic                  ARESET,
    axi4_if.master_mp             axi_if,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic                  cmd_write,
    input  logic [ADDR_WIDTH-1:0] cmd_addr,
    input  logic [7:0]            cmd_len,
    input  logic [2:0]            cmd_size,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  wr_valid,
    output logic                  wr_ready,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  rd_valid,
    input  logic                  rd_ready,
    output logic                  rd_last,
    output logic                  done_valid,
    output logic                  done_write,
    output logic [1:0]            done_resp,
    output logic                  done_lasterr
);

    mst_state_e            state_q, state_d;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [7:0]            len_q;
    logic [7:0]            beat_cnt_q;
    logic [2:0]            size_q;
    logic                  write_q;
    logic [1:0]            resp_q;
    logic                  lasterr_q;

    logic cmd_fire;
    logic w_fire;
    logic r_fire;
    logic last_beat;

    assign cmd_fire  = cmd_valid && (state_q == ST_IDLE);
    assign w_fire    = (state_q == ST_WR) && wr_valid && axi_if.wready;
    assign r_fire    = (state_q == ST_RD) && axi_if.rvalid && rd_ready;
    assign last_beat = (beat_cnt_q == len_q);

    // Payload is held from the latched command, so it is stable for the
    // whole time VALID is up regardless of what the requester does next.
    assign axi_if.awaddr = addr_q;
    assign axi_if.awlen  = len_q;
    assign axi_if.awsize = size_q;
    assign axi_if.araddr = addr_q;
    assign axi_if.arlen  = len_q;
    assign axi_if.arsize = size_q;
    assign axi_if.wdata  = wr_data;
    assign rd_data       = axi_if.rdata;

    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            state_q    <= ST_IDLE;
            addr_q     <= '0;
            len_q      <= '0;
            size_q     <= '0;
            write_q    <= 1'b0;
            beat_cnt_q <= '0;
            resp_q     <= RESP_OKAY;
            lasterr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            if (cmd_fire) begin
                addr_q     <= cmd_addr;
                len_q      <= cmd_len;
                size_q     <= cmd_size;
                write_q    <= cmd_write;
                beat_cnt_q <= '0;
                resp_q     <= RESP_OKAY;
                lasterr_q  <= 1'b0;
            end
            if (w_fire || r_fire) begin
                beat_cnt_q <= beat_cnt_q + 8'd1;
            end
            if ((state_q == ST_B) && axi_if.bvalid) begin
                resp_q <= axi_if.bresp;
            end
            // Read errors are sticky: a later OKAY beat never clears them.
            if (r_fire && (axi_if.rresp != RESP_OKAY)) begin
                resp_q <= axi_if.rresp;
            end
            if (r_fire && (axi_if.rlast || last_beat)) begin
                lasterr_q <= axi_if.rlast != last_beat;
            end
        end
    end

    always_comb begin
        state_d        = state_q;
        cmd_ready      = 1'b0;
        axi_if.awvalid = 1'b0;
        axi_if.wvalid  = 1'b0;
        axi_if.wlast   = 1'b0;
        axi_if.bready  = 1'b0;
        axi_if.arvalid = 1'b0;
        axi_if.rready  = 1'b0;
        wr_ready       = 1'b0;
        rd_valid       = 1'b0;
        rd_last        = 1'b0;
        done_valid     = 1'b0;
        done_write     = 1'b0;
        done_resp      = RESP_OKAY;
        done_lasterr   = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                cmd_ready = !ARESET;
                if (cmd_valid) begin
                    state_d = cmd_write ? ST_AW : ST_AR;
                end
            end
            ST_AW: begin
                axi_if.awvalid = 1'b1;
                if (axi_if.awready) begin
                    state_d = ST_WR;
                end
            end
            ST_WR: begin
                axi_if.wvalid = wr_valid;
                axi_if.wlast  = last_beat;
                wr_ready      = axi_if.wready;
                if (w_fire && last_beat) begin
                    state_d = ST_B;
                end
            end
            ST_B: begin
                axi_if.bready = 1'b1;
                if (axi_if.bvalid) begin
                    state_d = ST_DONE;
                end
            end
            ST_AR: begin
                axi_if.arvalid = 1'b1;
                if (axi_if.arready) begin
                    state_d = ST_RD;
                end
            end
            ST_RD: begin
                rd_valid      = axi_if.rvalid;
                rd_last       = axi_if.rlast;
                axi_if.rready = rd_ready;
                if (r_fire && (axi_if.rlast || last_beat)) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                done_valid   = 1'b1;
                done_write   = write_q;
                done_resp    = resp_q;
                done_lasterr = lasterr_q;
                state_d      = ST_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_axi4_cmd_master.sv
// Directed bench for axi4_cmd_master with a small behavioural
// AXI4 memory slave (1024 words, SLVERR on 4KB cross or out of range).
module tb_axi4_cmd_master;

    localparam int DW    = 32;
    localparam int AW    = 16;
    localparam int DEPTH = 1024;

    logic ACLK   = 1'b0;
    logic ARESET = 1'b1;
    always #5 ACLK = ~ACLK;

    axi4_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) axi_if ();

    logic          cmd_valid = 1'b0;
    logic          cmd_ready;
    logic          cmd_write = 1'b0;
    logic [AW-1:0] cmd_addr  = '0;
    logic [7:0]    cmd_len   = '0;
    logic [2:0]    cmd_size  = '0;
    logic [DW-1:0] wr_data   = '0;
    logic          wr_valid  = 1'b0;
    logic          wr_ready;
    logic [DW-1:0] rd_data;
    logic          rd_valid;
    logic          rd_ready  = 1'b1;
    logic          rd_last;
    logic          done_valid;
    logic          done_write;
    logic [1:0]    done_resp;
    logic          done_lasterr;

    axi4_cmd_master #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
        .ACLK         (ACLK),
        .ARESET       (ARESET),
        .axi_if       (axi_if.master_mp),
        .cmd_valid    (cmd_valid),
        .cmd_ready    (cmd_ready),
        .cmd_write    (cmd_write),
        .cmd_addr     (cmd_addr),
        .cmd_len      (cmd_len),
        .cmd_size     (cmd_size),
        .wr_data      (wr_data),
        .wr_valid     (wr_valid),
        .wr_ready     (wr_ready),
        .rd_data      (rd_data),
        .rd_valid     (rd_valid),
        .rd_ready     (rd_ready),
        .rd_last      (rd_last),
        .done_valid   (done_valid),
        .done_write   (done_write),
        .done_resp    (done_resp),
        .done_lasterr (done_lasterr)
    );

    int checks = 0;
    int errors = 0;

    // ---------------- slave model ----------------
    logic [DW-1:0] mem [DEPTH];
    typedef enum {SL_IDLE, SL_W, SL_B, SL_R} sl_e;
    sl_e           sl;
    logic [AW-1:0] s_addr;
    logic [7:0]    s_len;
    logic [2:0]    s_size;
    int            s_beat;
    bit            s_err;
    int            aw_wait;
    int            ar_wait;
    int unsigned   s_idx;
    bit            w_rand = 1'b0;

    function automatic int unsigned word_idx(input logic [AW-1:0] a,
                                             input logic [2:0] s,
                                             input int beat);
        return (32'(a) + (32'(beat) << s)) >> 2;
    endfunction

    function automatic bit crosses(input logic [AW-1:0] a,
                                   input logic [7:0] l,
                                   input logic [2:0] s);
        return ((32'(a) % 4096) + ((32'(l) + 1) << s)) > 4096;
    endfunction

    function automatic logic [DW-1:0] rd_word(input int unsigned i);
        return (i < DEPTH) ? mem[i] : '0;
    endfunction

    always @(posedge ACLK) begin
        if (ARESET) begin
            sl             <= SL_IDLE;
            axi_if.awready <= 1'b0;
            axi_if.wready  <= 1'b0;
            axi_if.bvalid  <= 1'b0;
            axi_if.bresp   <= 2'b00;
            axi_if.arready <= 1'b0;
            axi_if.rvalid  <= 1'b0;
            axi_if.rlast   <= 1'b0;
            axi_if.rresp   <= 2'b00;
            axi_if.rdata   <= '0;
            aw_wait        <= 0;
            ar_wait        <= 0;
        end else begin
            case (sl)
                SL_IDLE: begin
                    if (axi_if.awvalid && axi_if.awready) begin
                        axi_if.awready <= 1'b0;
                        aw_wait        <= 0;
                        s_addr         <= axi_if.awaddr;
                        s_len          <= axi_if.awlen;
                        s_size         <= axi_if.awsize;
                        s_beat         <= 0;
                        s_err          <= crosses(axi_if.awaddr, axi_if.awlen, axi_if.awsize);
                        axi_if.wready  <= w_rand ? 1'($urandom_range(0, 1)) : 1'b1;
                        sl             <= SL_W;
                    end else if (axi_if.arvalid && axi_if.arready) begin
                        axi_if.arready <= 1'b0;
                        ar_wait        <= 0;
                        s_addr         <= axi_if.araddr;
                        s_len          <= axi_if.arlen;
                        s_size         <= axi_if.arsize;
                        s_beat         <= 0;
                        s_err          <= crosses(axi_if.araddr, axi_if.arlen, axi_if.arsize);
                        s_idx           = word_idx(axi_if.araddr, axi_if.arsize, 0);
                        axi_if.rvalid  <= 1'b1;
                        axi_if.rdata   <= rd_word(s_idx);
                        axi_if.rlast   <= (axi_if.arlen == 8'd0);
                        axi_if.rresp   <= (crosses(axi_if.araddr, axi_if.arlen, axi_if.arsize)
                                           || s_idx >= DEPTH) ? 2'b10 : 2'b00;
                        sl             <= SL_R;
                    end else begin
                        if (axi_if.awvalid) begin
                            aw_wait <= aw_wait + 1;
                            if (aw_wait >= 2) axi_if.awready <= 1'b1;
                        end
                        if (axi_if.arvalid) begin
                            ar_wait <= ar_wait + 1;
                            if (ar_wait >= 2) axi_if.arready <= 1'b1;
                        end
                    end
                end
                SL_W: begin
                    axi_if.wready <= w_rand ? 1'($urandom_range(0, 1)) : 1'b1;
                    if (axi_if.wvalid && axi_if.wready) begin
                        s_idx = word_idx(s_addr, s_size, s_beat);
                        if (s_idx < DEPTH) mem[s_idx] <= axi_if.wdata;
                        else               s_err      <= 1'b1;
                        s_beat <= s_beat + 1;
                        if (s_beat == int'(s_len)) begin
                            axi_if.wready <= 1'b0;
                            axi_if.bvalid <= 1'b1;
                            axi_if.bresp  <= (s_err || s_idx >= DEPTH) ? 2'b10 : 2'b00;
                            sl            <= SL_B;
                        end
                    end
                end
                SL_B: begin
                    if (axi_if.bvalid && axi_if.bready) begin
                        axi_if.bvalid <= 1'b0;
                        sl            <= SL_IDLE;
                    end
                end
                SL_R: begin
                    if (axi_if.rvalid && axi_if.rready) begin
                        if (axi_if.rlast) begin
                            axi_if.rvalid <= 1'b0;
                            axi_if.rlast  <= 1'b0;
                            sl            <= SL_IDLE;
                        end else begin
                            s_idx         = word_idx(s_addr, s_size, s_beat + 1);
                            s_beat       <= s_beat + 1;
                            axi_if.rdata <= rd_word(s_idx);
                            axi_if.rlast <= (s_beat + 1 == int'(s_len));
                            axi_if.rresp <= (s_err || s_idx >= DEPTH) ? 2'b10 : 2'b00;
                        end
                    end
                end
                default: sl <= SL_IDLE;
            endcase
        end
    end

    // ---------------- requester-side drivers ----------------
    logic [DW-1:0] wq [$];
    bit            w_gap    = 1'b0;
    bit            w_hs     = 1'b0;
    bit            r_toggle = 1'b0;

    always @(posedge ACLK) begin
        #1;
        if (w_hs && wq.size() > 0) void'(wq.pop_front());
        if (wq.size() > 0) begin
            wr_data  = wq[0];
            wr_valid = w_gap ? 1'($urandom_range(0, 1)) : 1'b1;
        end else begin
            wr_data  = '0;
            wr_valid = 1'b0;
        end
        rd_ready = r_toggle ? ~rd_ready : 1'b1;
    end

    // ---------------- monitors ----------------
    logic [DW-1:0] wd_q [$];
    bit            wl_q [$];
    logic [DW-1:0] rd_q [$];
    bit            rl_q [$];
    int            done_cnt     = 0;
    int            done_rdy_bad = 0;
    int            aw_unstable  = 0;
    int            ar_unstable  = 0;
    logic          dn_write;
    logic [1:0]    dn_resp;
    logic          dn_lasterr;
    bit            aw_pend = 1'b0;
    bit            ar_pend = 1'b0;
    logic [AW+10:0] aw_prev;
    logic [AW+10:0] ar_prev;

    always @(negedge ACLK) begin
        w_hs = wr_valid && wr_ready;
        if (axi_if.wvalid && axi_if.wready) begin
            wd_q.push_back(axi_if.wdata);
            wl_q.push_back(axi_if.wlast);
        end
        if (rd_valid && rd_ready) begin
            rd_q.push_back(rd_data);
            rl_q.push_back(rd_last);
        end
        if (done_valid) begin
            done_cnt++;
            dn_write   = done_write;
            dn_resp    = done_resp;
            dn_lasterr = done_lasterr;
            if (cmd_ready) done_rdy_bad++;
        end
        if (aw_pend && (!axi_if.awvalid ||
            {axi_if.awaddr, axi_if.awlen, axi_if.awsize} !== aw_prev))
            aw_unstable++;
        if (ar_pend && (!axi_if.arvalid ||
            {axi_if.araddr, axi_if.arlen, axi_if.arsize} !== ar_prev))
            ar_unstable++;
        aw_pend = axi_if.awvalid && !axi_if.awready && !ARESET;
        ar_pend = axi_if.arvalid && !axi_if.arready && !ARESET;
        aw_prev = {axi_if.awaddr, axi_if.awlen, axi_if.awsize};
        ar_prev = {axi_if.araddr, axi_if.arlen, axi_if.arsize};
    end

    // ---------------- helpers ----------------
    task automatic issue(input bit wr, input logic [AW-1:0] a,
                         input logic [7:0] l, input logic [2:0] s);
        int n;
        @(posedge ACLK);
        #1;
        wd_q.delete(); wl_q.delete(); rd_q.delete(); rl_q.delete();
        cmd_write = wr;
        cmd_addr  = a;
        cmd_len   = l;
        cmd_size  = s;
        cmd_valid = 1'b1;
        n = 0;
        @(negedge ACLK);
        while (!cmd_ready && n < 50) begin
            @(negedge ACLK);
            n++;
        end
        @(posedge ACLK);
        #1 cmd_valid = 1'b0;
    endtask

    task automatic run_cmd(input bit wr, input logic [AW-1:0] a,
                           input logic [7:0] l, input logic [2:0] s,
                           input string name);
        int base;
        int n;
        base = done_cnt;
        issue(wr, a, l, s);
        n = 0;
        while (done_cnt == base && n < 3000) begin
            @(negedge ACLK);
            n++;
        end
        checks++;
        if (done_cnt != base + 1) begin
            errors++;
            $display("FAIL %s done_pulses got=%0d exp=1", name, done_cnt - base);
        end
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset;
        ARESET = 1'b1;
        repeat (3) @(posedge ACLK);
        #1;
        checks++;
        if (cmd_ready !== 1'b0) begin
            errors++;
            $display("FAIL reset_cmd_ready got=%b exp=0", cmd_ready);
        end
        checks++;
        if ({axi_if.awvalid, axi_if.wvalid, axi_if.arvalid, axi_if.bready,
             axi_if.rready, wr_ready, rd_valid, rd_last} !== 8'h00) begin
            errors++;
            $display("FAIL reset_handshakes got=%b exp=00000000",
                     {axi_if.awvalid, axi_if.wvalid, axi_if.arvalid, axi_if.bready,
                      axi_if.rready, wr_ready, rd_valid, rd_last});
        end
        checks++;
        if ({done_valid, done_write, done_resp, done_lasterr} !== 5'b0) begin
            errors++;
            $display("FAIL reset_done got=%b exp=00000",
                     {done_valid, done_write, done_resp, done_lasterr});
        end
        ARESET = 1'b0;
        @(posedge ACLK);
        #1;
        checks++;
        if (cmd_ready !== 1'b1) begin
            errors++;
            $display("FAIL release_cmd_ready got=%b exp=1", cmd_ready);
        end
    endtask

    task automatic test_write_basic;
        logic [DW-1:0] got;
        for (int i = 0; i < 4; i++) wq.push_back(32'hA0 + i);
        run_cmd(1'b1, 16'h0010, 8'd3, 3'd2, "wr_basic");
        for (int i = 0; i < 4; i++) begin
            got = (i < wd_q.size()) ? wd_q[i] : 'x;
            checks++;
            if (got !== 32'hA0 + i) begin
                errors++;
                $display("FAIL wr_basic_wdata[%0d] got=%h exp=%h", i, got, 32'hA0 + i);
            end
            checks++;
            if (i >= wl_q.size() || wl_q[i] != (i == 3)) begin
                errors++;
                $display("FAIL wr_basic_wlast[%0d] got=%0d exp=%0d", i,
                         (i < wl_q.size()) ? int'(wl_q[i]) : -1, (i == 3));
            end
        end
        checks++;
        if (dn_write !== 1'b1 || dn_resp !== 2'b00) begin
            errors++;
            $display("FAIL wr_basic_done write/resp got=%b/%b exp=1/00", dn_write, dn_resp);
        end
    endtask

    task automatic test_read_basic;
        logic [DW-1:0] got;
        run_cmd(1'b0, 16'h0010, 8'd3, 3'd2, "rd_basic");
        for (int i = 0; i < 4; i++) begin
            got = (i < rd_q.size()) ? rd_q[i] : 'x;
            checks++;
            if (got !== 32'hA0 + i) begin
                errors++;
                $display("FAIL rd_basic_data[%0d] got=%h exp=%h", i, got, 32'hA0 + i);
            end
            checks++;
            if (i >= rl_q.size() || rl_q[i] != (i == 3)) begin
                errors++;
                $display("FAIL rd_basic_last[%0d] got=%0d exp=%0d", i,
                         (i < rl_q.size()) ? int'(rl_q[i]) : -1, (i == 3));
            end
        end
        checks++;
        if ({dn_write, dn_resp, dn_lasterr} !== 4'b0000) begin
            errors++;
            $display("FAIL rd_basic_done write/resp/lasterr got=%b exp=0000",
                     {dn_write, dn_resp, dn_lasterr});
        end
    endtask

    task automatic test_write_4k;
        for (int i = 0; i < 4; i++) wq.push_back(32'hC0 + i);
        run_cmd(1'b1, 16'h0FF8, 8'd3, 3'd2, "wr_4k");
        checks++;
        if (dn_resp !== 2'b10) begin
            errors++;
            $display("FAIL wr_4k_resp got=%b exp=10", dn_resp);
        end
        checks++;
        if (wd_q.size() != 4) begin
            errors++;
            $display("FAIL wr_4k_beats got=%0d exp=4", wd_q.size());
        end
    endtask

    task automatic test_read_oob;
        logic [DW-1:0] got;
        run_cmd(1'b0, 16'h1000, 8'd0, 3'd2, "rd_oob");
        got = (rd_q.size() > 0) ? rd_q[0] : 'x;
        checks++;
        if (got !== 32'h0 || rd_q.size() != 1) begin
            errors++;
            $display("FAIL rd_oob_data got=%h beats=%0d exp=0 beats=1", got, rd_q.size());
        end
        checks++;
        if (dn_resp !== 2'b10 || dn_lasterr !== 1'b0) begin
            errors++;
            $display("FAIL rd_oob_done resp/lasterr got=%b/%b exp=10/0", dn_resp, dn_lasterr);
        end
    endtask

    task automatic test_gaps;
        logic [DW-1:0] got;
        w_gap  = 1'b1;
        w_rand = 1'b1;
        for (int i = 0; i < 8; i++) wq.push_back(32'hB000_0000 + 32'(i * 3 + 1));
        run_cmd(1'b1, 16'h0100, 8'd7, 3'd2, "gap_wr");
        w_gap  = 1'b0;
        w_rand = 1'b0;
        for (int i = 0; i < 8; i++) begin
            got = (i < wd_q.size()) ? wd_q[i] : 'x;
            checks++;
            if (got !== 32'hB000_0000 + 32'(i * 3 + 1)) begin
                errors++;
                $display("FAIL gap_wdata[%0d] got=%h exp=%h", i, got,
                         32'hB000_0000 + 32'(i * 3 + 1));
            end
        end
        checks++;
        if (dn_resp !== 2'b00) begin
            errors++;
            $display("FAIL gap_wr_resp got=%b exp=00", dn_resp);
        end
        r_toggle = 1'b1;
        run_cmd(1'b0, 16'h0100, 8'd7, 3'd2, "gap_rd");
        r_toggle = 1'b0;
        for (int i = 0; i < 8; i++) begin
            got = (i < rd_q.size()) ? rd_q[i] : 'x;
            checks++;
            if (got !== 32'hB000_0000 + 32'(i * 3 + 1)) begin
                errors++;
                $display("FAIL gap_rdata[%0d] got=%h exp=%h", i, got,
                         32'hB000_0000 + 32'(i * 3 + 1));
            end
        end
        checks++;
        if (rl_q.size() != 8 || rl_q[7] != 1'b1 || dn_lasterr !== 1'b0) begin
            errors++;
            $display("FAIL gap_rd_last beats=%0d lasterr=%b exp beats=8 lasterr=0",
                     rl_q.size(), dn_lasterr);
        end
        checks++;
        if (aw_unstable != 0 || ar_unstable != 0) begin
            errors++;
            $display("FAIL addr_stable aw=%0d ar=%0d exp=0/0", aw_unstable, ar_unstable);
        end
    endtask

    task automatic test_reset_mid;
        int base;
        int n;
        for (int i = 0; i < 8; i++) wq.push_back(32'hD0 + i);
        base = done_cnt;
        issue(1'b1, 16'h0040, 8'd7, 3'd2);
        n = 0;
        while (wd_q.size() < 1 && n < 200) begin
            @(negedge ACLK);
            n++;
        end
        checks++;
        if (wd_q.size() < 1) begin
            errors++;
            $display("FAIL mid_reset_start beats=%0d exp>=1", wd_q.size());
        end
        @(posedge ACLK);
        #1 ARESET = 1'b1;
        @(posedge ACLK);
        #1;
        checks++;
        if ({axi_if.awvalid, axi_if.wvalid, axi_if.arvalid, axi_if.bready,
             axi_if.rready, wr_ready, rd_valid, done_valid} !== 8'h00) begin
            errors++;
            $display("FAIL mid_reset_valids got=%b exp=00000000",
                     {axi_if.awvalid, axi_if.wvalid, axi_if.arvalid, axi_if.bready,
                      axi_if.rready, wr_ready, rd_valid, done_valid});
        end
        wq.delete();
        @(posedge ACLK);
        #1 ARESET = 1'b0;
        repeat (4) @(posedge ACLK);
        checks++;
        if (done_cnt != base) begin
            errors++;
            $display("FAIL mid_reset_no_done got=%0d exp=0", done_cnt - base);
        end
        wq.push_back(32'hE0);
        run_cmd(1'b1, 16'h0020, 8'd0, 3'd2, "after_reset");
        checks++;
        if (dn_write !== 1'b1 || dn_resp !== 2'b00) begin
            errors++;
            $display("FAIL after_reset_done write/resp got=%b/%b exp=1/00", dn_write, dn_resp);
        end
        checks++;
        if (done_rdy_bad != 0) begin
            errors++;
            $display("FAIL cmd_ready_in_done got=%0d exp=0", done_rdy_bad);
        end
    endtask

    initial begin
        test_reset();
        test_write_basic();
        test_read_basic();
        test_write_4k();
        test_read_oob();
        test_gaps();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
